// File: rtl/if_stage_if.sv
// if_stage_if: decode-side handshake, redirect bus and instruction SRAM port of the fetch stage.
interface if_stage_if #(
    parameter int PC_WIDTH    = 32,
    parameter int INSTR_WIDTH = 32
);
    logic                            id_allow_in;
    logic                            if_to_id_valid;
    logic [PC_WIDTH+INSTR_WIDTH-1:0] if_to_id_bus;
    logic [PC_WIDTH+1:0]             id_to_if_bus;
    logic                            inst_sram_req;
    logic [31:0]                     inst_sram_addr;
    logic                            inst_sram_addr_ok;
    logic                            inst_sram_data_ok;
    logic [INSTR_WIDTH-1:0]          inst_sram_rdata;

    modport master (
        input  id_allow_in, id_to_if_bus, inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
        output if_to_id_valid, if_to_id_bus, inst_sram_req, inst_sram_addr
    );

    modport slave (
        output id_allow_in, id_to_if_bus, inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
        input  if_to_id_valid, if_to_id_bus, inst_sram_req, inst_sram_addr
    );
endinterface

// File: rtl/if_stage.sv
// if_stage: RV32I fetch stage; owns the PC, keeps one SRAM request in flight and
// buffers one response while decode stalls.
module if_stage #(
    parameter int                PC_WIDTH    = 32,
    parameter int                INSTR_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC  = 32'h8000_0000
) (
    input logic      clk,
    input logic      rst,
    if_stage_if.master io
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t                 state_q, state_d;
    logic [PC_WIDTH-1:0]    fetch_pc_q, fetch_pc_d, req_pc_q, req_pc_d;
    logic [PC_WIDTH-1:0]    out_pc_q, out_pc_d, buf_pc_q, buf_pc_d;
    logic [INSTR_WIDTH-1:0] out_inst_q, out_inst_d, buf_inst_q, buf_inst_d;
    logic                   out_valid_q, out_valid_d, buf_valid_q, buf_valid_d;
    logic                   discard_q, discard_d;
    logic                   cancel, hs, xfer, take, unused_taken;
    logic [PC_WIDTH-1:0]    target;

    assign cancel       = io.id_to_if_bus[0];
    assign target       = io.id_to_if_bus[PC_WIDTH:1];
    assign unused_taken = io.id_to_if_bus[PC_WIDTH+1];
    assign xfer         = out_valid_q && io.id_allow_in;
    assign hs           = state_q == REQ && !buf_valid_q && io.inst_sram_addr_ok;
    assign take         = state_q == WAIT && io.inst_sram_data_ok && !discard_q && !cancel;

    assign io.inst_sram_req  = state_q == REQ && !buf_valid_q;
    assign io.inst_sram_addr = 32'(fetch_pc_q);
    assign io.if_to_id_valid = out_valid_q;
    assign io.if_to_id_bus   = {out_pc_q, out_inst_q};

    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        req_pc_d    = req_pc_q;
        out_valid_d = out_valid_q;
        out_pc_d    = out_pc_q;
        out_inst_d  = out_inst_q;
        buf_valid_d = buf_valid_q;
        buf_pc_d    = buf_pc_q;
        buf_inst_d  = buf_inst_q;
        discard_d   = discard_q;
        if (state_q == IDLE) state_d = REQ;
        if (hs) begin
            req_pc_d   = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + PC_WIDTH'(4);
            state_d    = WAIT;
            discard_d  = cancel;
        end
        if (state_q == WAIT) begin
            if (io.inst_sram_data_ok) begin
                state_d   = REQ;
                discard_d = 1'b0;
            end else if (cancel) begin
                discard_d = 1'b1;
            end
        end
        if (xfer) begin
            out_valid_d = buf_valid_q;
            out_pc_d    = buf_pc_q;
            out_inst_d  = buf_inst_q;
            buf_valid_d = 1'b0;
        end
        // a response lands in the output slot unless it is still held by decode
        if (take && (!out_valid_q || xfer)) begin
            out_valid_d = 1'b1;
            out_pc_d    = req_pc_q;
            out_inst_d  = io.inst_sram_rdata;
        end else if (take) begin
            buf_valid_d = 1'b1;
            buf_pc_d    = req_pc_q;
            buf_inst_d  = io.inst_sram_rdata;
        end
        if (cancel) begin
            out_valid_d = 1'b0;
            buf_valid_d = 1'b0;
            fetch_pc_d  = target;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            fetch_pc_q  <= RESET_PC;
            req_pc_q    <= RESET_PC;
            out_valid_q <= 1'b0;
            out_pc_q    <= '0;
            out_inst_q  <= '0;
            buf_valid_q <= 1'b0;
            buf_pc_q    <= '0;
            buf_inst_q  <= '0;
            discard_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            req_pc_q    <= req_pc_d;
            out_valid_q <= out_valid_d;
            out_pc_q    <= out_pc_d;
            out_inst_q  <= out_inst_d;
            buf_valid_q <= buf_valid_d;
            buf_pc_q    <= buf_pc_d;
            buf_inst_q  <= buf_inst_d;
            discard_q   <= discard_d;
        end
    end
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: cycle-by-cycle directed vectors for the fetch stage; the bench plays
// decode and the instruction SRAM, driving addr_ok/data_ok/rdata directly.
module tb_if_stage;
    typedef struct {
        logic        allow, cancel;
        logic [31:0] tgt;
        logic        aok, dok;
        logic [31:0] rd;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc, e_inst;
    } vec_t;

    localparam logic [31:0] I0 = 32'h0000_0013, I1 = 32'h0040_0093, I2 = 32'h0080_0113;
    localparam logic [31:0] I3 = 32'h00c0_0193, I4 = 32'hdead_beef, I5 = 32'h1000_0517;
    localparam logic [31:0] I6 = 32'hbad0_0001, I7 = 32'hbad0_0002, I8 = 32'h0000_006f;
    localparam logic [31:0] I9 = 32'h0010_0073, IA = 32'h0000_1537;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    vec_t tbl[$];

    if_stage_if bus_if ();
    if_stage dut (.clk(clk), .rst(rst), .io(bus_if.slave));

    always #5 clk = ~clk;

    task automatic row(input logic a, c, input logic [31:0] t, input logic ao, dk,
                       input logic [31:0] rd, input logic er, input logic [31:0] ea,
                       input logic ev, input logic [31:0] ep, ei);
        vec_t v;
        v = '{a, c, t, ao, dk, rd, er, ea, ev, ep, ei};
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input logic [63:0] act, exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic step(input vec_t v);
        @(negedge clk);
        bus_if.id_allow_in       = v.allow;
        bus_if.id_to_if_bus      = {1'b0, v.tgt, v.cancel};
        bus_if.inst_sram_addr_ok = v.aok;
        bus_if.inst_sram_data_ok = v.dok;
        bus_if.inst_sram_rdata   = v.rd;
        #1;
        chk("req", 64'(bus_if.inst_sram_req), 64'(v.e_req));
        chk("addr", 64'(bus_if.inst_sram_addr), 64'(v.e_addr));
        chk("valid", 64'(bus_if.if_to_id_valid), 64'(v.e_valid));
        if (v.e_valid) chk("bus", bus_if.if_to_id_bus, {v.e_pc, v.e_inst});
    endtask

    task automatic release_rst();
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        bus_if.id_allow_in       = 1'b1;
        bus_if.id_to_if_bus      = '0;
        bus_if.inst_sram_addr_ok = 1'b0;
        bus_if.inst_sram_data_ok = 1'b0;
        bus_if.inst_sram_rdata   = '0;
        // steady fetch, one instruction every two cycles
        row(1, 0, 0, 1, 0, 0,  0, 32'h8000_0000, 0, 0, 0);
        row(1, 0, 0, 1, 0, 0,  1, 32'h8000_0000, 0, 0, 0);
        row(1, 0, 0, 1, 1, I0, 0, 32'h8000_0004, 0, 0, 0);
        row(1, 0, 0, 1, 0, 0,  1, 32'h8000_0004, 1, 32'h8000_0000, I0);
        row(1, 0, 0, 1, 1, I1, 0, 32'h8000_0008, 0, 0, 0);
        row(1, 0, 0, 1, 0, 0,  1, 32'h8000_0008, 1, 32'h8000_0004, I1);
        row(1, 0, 0, 1, 1, I2, 0, 32'h8000_000c, 0, 0, 0);
        // decode stalls six cycles; second response parks in the buffer
        row(0, 0, 0, 1, 0, 0,  1, 32'h8000_000c, 1, 32'h8000_0008, I2);
        row(0, 0, 0, 1, 1, I3, 0, 32'h8000_0010, 1, 32'h8000_0008, I2);
        for (int i = 0; i < 4; i++)
            row(0, 0, 0, 1, 0, 0, 0, 32'h8000_0010, 1, 32'h8000_0008, I2);
        row(1, 0, 0, 1, 0, 0,  0, 32'h8000_0010, 1, 32'h8000_0008, I2);
        row(1, 0, 0, 1, 0, 0,  1, 32'h8000_0010, 1, 32'h8000_000c, I3);
        // cancel in WAIT, stale response arrives two cycles later
        row(1, 1, 32'h8000_0100, 1, 0, 0,  0, 32'h8000_0014, 0, 0, 0);
        row(1, 0, 0, 1, 0, 0,  0, 32'h8000_0100, 0, 0, 0);
        row(1, 0, 0, 1, 1, I4, 0, 32'h8000_0100, 0, 0, 0);
        row(1, 0, 0, 1, 0, 0,  1, 32'h8000_0100, 0, 0, 0);
        row(1, 0, 0, 1, 1, I5, 0, 32'h8000_0104, 0, 0, 0);
        row(1, 0, 0, 1, 0, 0,  1, 32'h8000_0104, 1, 32'h8000_0100, I5);
        // cancel together with data_ok: dropped, discard must stay clear
        row(1, 1, 32'h8000_0100, 1, 1, I6, 0, 32'h8000_0108, 0, 0, 0);
        row(1, 0, 0, 1, 0, 0,  1, 32'h8000_0100, 0, 0, 0);
        row(1, 0, 0, 1, 1, IA, 0, 32'h8000_0104, 0, 0, 0);
        // addr_ok low three cycles, redirect while the request waits
        row(1, 0, 0, 0, 0, 0,  1, 32'h8000_0104, 1, 32'h8000_0100, IA);
        row(1, 1, 32'h8000_0200, 0, 0, 0, 1, 32'h8000_0104, 0, 0, 0);
        row(1, 0, 0, 0, 0, 0,  1, 32'h8000_0200, 0, 0, 0);
        // cancel with addr_ok: the accepted request's data is discarded
        row(1, 1, 32'h8000_0300, 1, 0, 0, 1, 32'h8000_0200, 0, 0, 0);
        row(1, 0, 0, 1, 1, I7, 0, 32'h8000_0300, 0, 0, 0);
        row(1, 0, 0, 1, 0, 0,  1, 32'h8000_0300, 0, 0, 0);
        row(1, 0, 0, 1, 1, I8, 0, 32'h8000_0304, 0, 0, 0);
        row(0, 0, 0, 1, 0, 0,  1, 32'h8000_0304, 1, 32'h8000_0300, I8);
        row(0, 0, 0, 1, 0, 0,  0, 32'h8000_0308, 1, 32'h8000_0300, I8);

        release_rst();
        for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

        // asynchronous reset mid-WAIT with the output slot holding an instruction
        #2 rst = 1'b1;
        #1;
        chk("rst_valid", 64'(bus_if.if_to_id_valid), 64'd0);
        chk("rst_req", 64'(bus_if.inst_sram_req), 64'd0);
        chk("rst_addr", 64'(bus_if.inst_sram_addr), 64'h8000_0000);
        bus_if.inst_sram_data_ok = 1'b0;
        release_rst();
        tbl.delete();
        row(1, 0, 0, 1, 0, 0,  0, 32'h8000_0000, 0, 0, 0);
        row(1, 0, 0, 1, 0, 0,  1, 32'h8000_0000, 0, 0, 0);
        row(1, 0, 0, 1, 1, I9, 0, 32'h8000_0004, 0, 0, 0);
        // redirect while decode holds a valid slot flushes it
        row(0, 1, 32'h8000_0400, 0, 0, 0, 1, 32'h8000_0004, 1, 32'h8000_0000, I9);
        row(1, 0, 0, 0, 0, 0,  1, 32'h8000_0400, 0, 0, 0);
        for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the TaoShuRV five-stage RV32I pipeline. It owns the PC and issues fetch requests to the instruction SRAM over a request/address-ok/data-ok interface. It delivers `{pc, inst}` to the decode stage through the valid/allow-in handshake. It also services the branch redirect bus coming back from decode. At most one SRAM request is outstanding. A one-entry response buffer absorbs a response that returns while decode is stalled.

## Interface
- `PC_WIDTH`, 32, PC width in bits
- `INSTR_WIDTH`, 32, instruction width in bits
- `RESET_PC`, 32'h8000_0000, first fetch address after reset

Ports:
- `clk`  in  1  single clock, all state on posedge
- `rst`  in  1  reset, asynchronous, active-high
- `id_allow_in`  in  1  decode can accept this cycle
- `if_to_id_valid`  out  1  output slot holds a valid instruction
- `if_to_id_bus`  out  PC_WIDTH+INSTR_WIDTH  `{pc, inst}`, pc in MSBs
- `id_to_if_bus`  in  PC_WIDTH+2  `{branch_taken, branch_target, branch_taken_cancel}`
- `inst_sram_req`  out  1  fetch request
- `inst_sram_addr`  out  32  fetch byte address
- `inst_sram_addr_ok`  in  1  request accepted (handshake = req && addr_ok)
- `inst_sram_data_ok`  in  1  response valid, one per accepted request, in order, at least 1 cycle after acceptance
- `inst_sram_rdata`  in  INSTR_WIDTH  response data, valid with data_ok

## Operation
- Registers:
  - `fetch_pc`: next address to request.
  - `req_pc`: PC of the in-flight request.
  - `out_valid/out_pc/out_inst`: output slot.
  - `buf_valid/buf_pc/buf_inst`: response buffer.
  - `discard`: in-flight response belongs to a cancelled path.
  - `state`.
- FSM states:
  - IDLE: reset state. Moves to REQ unconditionally on the next edge.
  - REQ:
    - `inst_sram_req = !buf_valid`, `inst_sram_addr = fetch_pc`.
    - On handshake: `req_pc <= fetch_pc`, `fetch_pc <= fetch_pc+4`, move to WAIT.
  - WAIT:
    - req low.
    - On `data_ok` with `discard=0`: the response is written to the output slot if the slot is empty or drained this cycle, otherwise to the buffer. Return to REQ.
    - On `data_ok` with `discard=1`: the response is dropped, `discard` is cleared, return to REQ.
- Output handshake:
  - `if_to_id_valid = out_valid`, `if_to_id_bus = {out_pc, out_inst}`.
  - A transfer occurs when `out_valid && id_allow_in`.
  - On transfer with `buf_valid`, the buffer moves to the output slot and `buf_valid` is cleared.
- Redirect: when `branch_taken_cancel=1`, the current output slot counts as consumed by decode, and the following happen on that edge:
  - `out_valid` and `buf_valid` are cleared.
  - `fetch_pc <= branch_target`.
- Redirect priority and simultaneous events:
  - Cancel in REQ without addr_ok: the address switches to the target next cycle. No discard.
  - Cancel in REQ with addr_ok: the old request is accepted. `discard <= 1`, go to WAIT, `fetch_pc <= branch_target` (not +4).
  - Cancel in WAIT without data_ok: `discard <= 1`, stay in WAIT.
  - Cancel in WAIT with data_ok: the response is dropped, go to REQ, `discard` stays 0.
  - A second cancel while `discard=1` only overwrites `fetch_pc`.
- `req` and `addr` may change before addr_ok only because of a redirect; otherwise both are held stable until the handshake.
- PC arithmetic is modulo 2^PC_WIDTH. The target is used unaligned as given; alignment is checked upstream.
- `branch_taken` alone has no effect; only `branch_taken_cancel` acts.

## Timing
- Reset values:
  - `if_to_id_valid=0`, `inst_sram_req=0`, `inst_sram_addr=RESET_PC`.
  - `state=IDLE`, `discard=0`, `fetch_pc=RESET_PC`.
  - Outputs take these values immediately when `rst` asserts.
- Reset mid-operation abandons any in-flight request. The SRAM shares `rst` and must not return a stale `data_ok` afterwards.
- Cycle timeline from the first edge after reset release, with addr_ok=1 and a 1-cycle memory:
  - Cycle 1: req high, addr=RESET_PC.
  - Cycle 2: data_ok.
  - Cycle 3: `if_to_id_valid=1`.
- Peak throughput: one instruction per 2 cycles. The earliest next request is the cycle after data_ok.
- Redirect latency: the first request to the target is issued in the cycle after cancel (REQ case), or the cycle after the discarded data_ok (WAIT case).
- No response is lost or duplicated. Delivery order equals request order.

## Test plan
- Reset, addr_ok=1, data_ok 1 cycle after acceptance, id_allow_in=1 -> requests to 0x80000000, 0x80000004, 0x80000008 every 2 cycles. Bus carries matching `{pc, rdata}`.
- Hold id_allow_in=0 for 6 cycles -> output slot held, second response goes to the buffer, req stays low. After release, pcs are delivered in order with no gaps.
- Cancel to 0x80000100 in WAIT, data_ok 2 cycles later -> old response dropped. Next accepted address is 0x80000100, next delivered pc is 0x80000100.
- Cancel in the same cycle as data_ok -> response dropped, next cycle req with addr 0x80000100, discard stays 0.
- addr_ok held low 3 cycles and cancel during REQ -> addr changes to the target without a discard. With cancel and addr_ok in the same cycle -> one response discarded.
- Assert rst mid-WAIT with the output slot valid -> `if_to_id_valid` and req drop immediately. After release, fetch restarts at 0x80000000.
